// File: rtl/picosoc_timer.sv
// picosoc_timer: memory-mapped down-counting timer for the PicoSoC iomem bus.
//
// Registers (word offsets within a 32-byte window at BASE_ADDR):
//   0x00 CTRL    [0] EN, [1] AUTO, [2] IRQEN
//   0x04 PRESC   [PRESC_W-1:0]
//   0x08 COUNT   down-counter, decremented on each prescaler tick
//   0x0C RELOAD  value loaded into COUNT on expiry when AUTO=1
//   0x10 STATUS  [0] EXP, [1] CAP, write-1-to-clear
//   0x14 CAPTURE COUNT snapshot on a capture_in rising edge (read-only)
//   0x18/0x1C    read 0, writes ignored
//
// Optional feature macro: PICOSOC_TIMER_CAPTURE_EN builds the capture_in
// synchronizer, the CAPTURE register and STATUS.CAP.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   iomem_valid/ready  request / one-cycle completion pulse
//   iomem_wstrb        byte write strobes, 0 = read
//   iomem_addr/wdata   byte address / write data
//   iomem_rdata        registered read data, 0 outside ready
//   capture_in         asynchronous capture trigger
//   irq                level interrupt (to irq_5)
module picosoc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        capture_in,
  output logic        irq
);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic               ready_q;
  logic [31:0]        rdata_q;
  logic               en_q, en_d;
  logic               auto_q, auto_d;
  logic               irqen_q, irqen_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        reload_q, reload_d;
  logic               exp_q, exp_d;
  logic               cap_q;
  logic [31:0]        capture_q;
  logic               cap_rise;

  logic        sel, access, wr;
  logic [2:0]  reg_idx;
  logic        wr_ctrl, wr_presc, wr_count, wr_reload, wr_status;
  logic        w1c_exp, w1c_cap;
  logic        tick, expire;
  logic [31:0] ctrl_word, presc_word, rd_word;
  logic [31:0] ctrl_new, presc_new32, count_new, reload_new;

  assign sel     = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
  // Accept a transaction only on the first cycle it is seen, so ready pulses once.
  assign access  = sel && !ready_q;
  assign wr      = access && (iomem_wstrb != 4'b0000);
  assign reg_idx = iomem_addr[4:2];

  assign wr_ctrl   = wr && (reg_idx == 3'd0);
  assign wr_presc  = wr && (reg_idx == 3'd1);
  assign wr_count  = wr && (reg_idx == 3'd2);
  assign wr_reload = wr && (reg_idx == 3'd3);
  assign wr_status = wr && (reg_idx == 3'd4);
  assign w1c_exp   = wr_status && iomem_wstrb[0] && iomem_wdata[0];
  assign w1c_cap   = wr_status && iomem_wstrb[0] && iomem_wdata[1];

  assign ctrl_word   = {29'd0, irqen_q, auto_q, en_q};
  assign presc_word  = 32'(presc_q);
  assign ctrl_new    = merge_bytes(ctrl_word, iomem_wdata, iomem_wstrb);
  assign presc_new32 = merge_bytes(presc_word, iomem_wdata, iomem_wstrb);
  assign count_new   = merge_bytes(count_q, iomem_wdata, iomem_wstrb);
  assign reload_new  = merge_bytes(reload_q, iomem_wdata, iomem_wstrb);

  assign tick   = en_q && (pcnt_q == '0);
  assign expire = tick && (count_q == 32'd0);

  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    irqen_d  = irqen_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    count_d  = count_q;
    reload_d = reload_q;
    exp_d    = exp_q;

    // Prescaler
    if (en_q) pcnt_d = tick ? presc_q : (pcnt_q - PRESC_W'(1));

    // Counter; AUTO=0 expiry stops the timer with COUNT left at 0
    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (auto_q) begin
        count_d = reload_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // Bus writes are applied last so they win over timer updates.
    if (wr_ctrl) begin
      en_d    = ctrl_new[0];
      auto_d  = ctrl_new[1];
      irqen_d = ctrl_new[2];
      pcnt_d  = presc_q;
    end
    if (wr_presc) begin
      presc_d = presc_new32[PRESC_W-1:0];
      pcnt_d  = presc_new32[PRESC_W-1:0];
    end
    if (wr_count)  count_d  = count_new;
    if (wr_reload) reload_d = reload_new;

    // Set beats clear
    if (w1c_exp) exp_d = 1'b0;
    if (expire)  exp_d = 1'b1;
  end

  always_comb begin
    rd_word = 32'd0;
    unique case (reg_idx)
      3'd0:    rd_word = ctrl_word;
      3'd1:    rd_word = presc_word;
      3'd2:    rd_word = count_q;
      3'd3:    rd_word = reload_q;
      3'd4:    rd_word = {30'd0, cap_q, exp_q};
      3'd5:    rd_word = capture_q;
      default: rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irqen_q  <= 1'b0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      count_q  <= 32'd0;
      reload_q <= 32'd0;
      exp_q    <= 1'b0;
    end else begin
      ready_q  <= access;
      rdata_q  <= access ? rd_word : 32'd0;
      en_q     <= en_d;
      auto_q   <= auto_d;
      irqen_q  <= irqen_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      exp_q    <= exp_d;
    end
  end

`ifdef PICOSOC_TIMER_CAPTURE_EN
  logic sync1_q, sync2_q, sync3_q;

  // Two flops for metastability, third flop for rising-edge detection.
  assign cap_rise = sync2_q && !sync3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      cap_q     <= 1'b0;
      capture_q <= 32'd0;
    end else begin
      sync1_q <= capture_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (cap_rise) begin
        cap_q     <= 1'b1;
        capture_q <= count_q;
      end else if (w1c_cap) begin
        cap_q <= 1'b0;
      end
    end
  end

  assign irq = (exp_q || cap_q) && irqen_q;

  logic unused_ok;
  assign unused_ok = ^{iomem_addr[1:0], ctrl_new[31:3], presc_new32};
`else
  assign cap_rise  = 1'b0;
  assign cap_q     = 1'b0;
  assign capture_q = 32'd0;

  assign irq = exp_q && irqen_q;

  logic unused_ok;
  assign unused_ok = ^{iomem_addr[1:0], ctrl_new[31:3], presc_new32, capture_in, w1c_cap,
                       cap_rise};
`endif

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

endmodule

// File: tb/tb_picosoc_timer.sv
// Self-checking bench for picosoc_timer: directed steps plus randomized
// register and timing runs checked against arithmetic expectations.
module tb_picosoc_timer;

  localparam logic [31:0] Base = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        capture_in;
  logic        irq;

  int unsigned cyc = 0;
  int unsigned last_ready_cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  picosoc_timer dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (valid),
    .iomem_ready (ready),
    .iomem_wstrb (wstrb),
    .iomem_addr  (addr),
    .iomem_wdata (wdata),
    .iomem_rdata (rdata),
    .capture_in  (capture_in),
    .irq         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transaction; returns at #1 after the edge following ready.
  task automatic xact(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] r, output logic got);
    int lat;
    lat = 0;
    got = 1'b0;
    r   = 32'd0;
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    wstrb = s;
    wdata = d;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        got = 1'b1;
        r   = rdata;
        lat = i;
        last_ready_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    wstrb = 4'b0000;
    @(posedge clk);
    #1;
    if (got) begin
      chk("ready_latency", 32'(lat), 32'd0);
      chk("ready_pulse", {31'd0, ready}, 32'd0);
      chk("rdata_idle", rdata, 32'd0);
    end
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] r;
    logic        got;
    xact(Base + 32'(off), 4'hF, d, r, got);
    chk("wr_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] r;
    logic        got;
    xact(Base + 32'(off), 4'h0, 32'd0, r, got);
    chk("rd_ack", {31'd0, got}, 32'd1);
    chk(tag, r, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles from t0 until irq is seen high (sampled #1 after each edge).
  task automatic wait_irq(input int unsigned t0, output int unsigned n);
    for (int k = 0; k < 600; k++) begin
      if (irq === 1'b1) break;
      @(posedge clk);
      #1;
    end
    chk("irq_seen", {31'd0, irq}, 32'd1);
    n = cyc - t0;
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] m;
    m = o;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  logic [31:0] mdl [8];

  initial begin
    logic [31:0] r;
    logic        got;
    int unsigned n, t0, p, c, rl, idx;
    logic [3:0]  s;
    logic [31:0] d;

    valid = 1'b0;
    wstrb = 4'b0000;
    addr  = 32'd0;
    wdata = 32'd0;
    capture_in = 1'b0;

    // Reset with a selected request pending: it must be dropped.
    reset = 1'b1;
    @(negedge clk);
    valid = 1'b1;
    addr  = Base;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("ready_in_reset", {31'd0, ready}, 32'd0);
    end
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b0;

    // Reset values
    for (int i = 0; i < 8; i++) rd_chk("reset_value", 5'(4 * i), 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // Address decode
    xact(Base + 32'h20, 4'hF, 32'h1, r, got);
    chk("decode_above", {31'd0, got}, 32'd0);
    xact(32'h0200_0000, 4'h0, 32'h0, r, got);
    chk("decode_other", {31'd0, got}, 32'd0);
    wr(5'h1C, 32'hFFFF_FFFF);
    rd_chk("unmapped_1c", 5'h1C, 32'd0);
    rd_chk("unmapped_18", 5'h18, 32'd0);

    // Byte strobes
    wr(5'h0C, 32'd0);
    xact(Base + 32'h0C, 4'b0010, 32'hCDEF_AB12, r, got);
    rd_chk("reload_byte1", 5'h0C, 32'h0000_AB00);

    // Randomized strobed writes with EN held 0
    for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
    mdl[3] = 32'h0000_AB00;
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 3);
      s   = 4'($urandom_range(1, 15));
      d   = $urandom;
      if (idx == 0) d[0] = 1'b0;
      mdl[idx] = bytes_merge(mdl[idx], d, s);
      if (idx == 0) mdl[0] = mdl[0] & 32'h6;
      if (idx == 1) mdl[1] = mdl[1] & 32'h0000_FFFF;
      xact(Base + 32'(4 * idx), s, d, r, got);
      rd_chk("rand_reg", 5'(4 * idx), mdl[idx]);
    end
    wr(5'h00, 32'd0);

    // One-shot directed case, then randomized ones
    for (int i = 0; i < 4; i++) begin
      p = (i == 0) ? 0 : $urandom_range(0, 3);
      c = (i == 0) ? 3 : $urandom_range(0, 9);
      wr(5'h04, p);
      wr(5'h08, c);
      wr(5'h00, 32'h5);
      t0 = last_ready_cyc;
      wait_irq(t0, n);
      chk("oneshot_delay", n, (c + 1) * (p + 1));
      rd_chk("oneshot_ctrl", 5'h00, 32'h4);
      rd_chk("oneshot_count", 5'h08, 32'd0);
      wr(5'h10, 32'h1);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
    end

    // Auto-reload: directed P=1,R=4, then randomized
    for (int i = 0; i < 3; i++) begin
      p  = (i == 0) ? 1 : $urandom_range(1, 3);
      rl = (i == 0) ? 4 : $urandom_range(1, 6);
      wr(5'h04, p);
      wr(5'h0C, rl);
      wr(5'h08, rl);
      wr(5'h00, 32'h7);
      t0 = last_ready_cyc;
      for (int k = 0; k < 5; k++) begin
        wait_irq(t0, n);
        chk("auto_period", n, (rl + 1) * (p + 1));
        t0 = cyc;
        wr(5'h10, 32'h1);
      end
      wr(5'h00, 32'h0);
      wr(5'h10, 32'h3);
    end

    // COUNT write coincident with a tick: write wins
    wr(5'h04, 32'd7);
    wr(5'h08, 32'h50);
    wr(5'h00, 32'h3);
    idle(6);
    wr(5'h08, 32'h20);
    rd_chk("count_write_wins", 5'h08, 32'h20);
    wr(5'h00, 32'h0);

    // W1C of EXP coincident with expiry: set wins, EN auto-clears
    wr(5'h04, 32'd0);
    wr(5'h08, 32'd2);
    wr(5'h00, 32'h1);
    idle(1);
    wr(5'h10, 32'h1);
    rd_chk("exp_set_wins", 5'h10, 32'h1);
    rd_chk("en_autocleared", 5'h00, 32'h0);
    wr(5'h10, 32'h1);
    rd_chk("exp_cleared", 5'h10, 32'h0);

`ifdef PICOSOC_TIMER_CAPTURE_EN
    wr(5'h04, 32'd0);
    wr(5'h08, 32'd100);
    wr(5'h00, 32'h5);
    t0 = last_ready_cyc;
    @(negedge clk);
    n = cyc;
    capture_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("cap_irq", {31'd0, irq}, 32'd1);
    capture_in = 1'b0;
    rd_chk("capture_value", 5'h14, 32'd100 - ((n + 2) - t0));
    rd_chk("cap_status", 5'h10, 32'h2);
    wr(5'h00, 32'h0);
    wr(5'h10, 32'h3);
`else
    @(negedge clk);
    capture_in = 1'b1;
    repeat (6) @(negedge clk);
    capture_in = 1'b0;
    rd_chk("no_cap_status", 5'h10, 32'h0);
    rd_chk("no_capture", 5'h14, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/picosoc_timer.md
# picosoc_timer

Memory-mapped down-counting timer with prescaler, auto-reload and interrupt output, attached to the PicoSoC external `iomem_*` bus. It decodes its own address window, answers single-cycle-latency read/write transactions from the CPU, and drives a level interrupt into one of the SoC's external IRQ inputs (`irq_5`). It is the first peripheral downstream of the SoC's iomem port.

## Interface
- `BASE_ADDR`, 32'h0300_0000: byte address of register 0; window is 32 bytes; `iomem_addr[4:2]` selects the register.
- `PRESC_W`, 16: prescaler width in bits, 1..32.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `iomem_valid` in 1: transaction request.
- `iomem_ready` out 1: transaction complete; one-cycle pulse.
- `iomem_wstrb` in 4: byte write strobes; 0 means read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data; valid while `iomem_ready`=1.
- `capture_in` in 1: asynchronous capture trigger. Ignored unless capture is compiled in.
- `irq` out 1: level interrupt, goes to `irq_5`.

## Operation
- **Select.** `sel = iomem_valid && iomem_addr[31:5] == BASE_ADDR[31:5]`. When not selected, `iomem_ready` stays 0 so another iomem slave can answer.
- **Register map** (offsets):
  - 0x00 CTRL: [0] EN, [1] AUTO, [2] IRQEN. Other bits read 0.
  - 0x04 PRESC: [PRESC_W-1:0].
  - 0x08 COUNT: 32 bits.
  - 0x0C RELOAD: 32 bits.
  - 0x10 STATUS: [0] EXP, [1] CAP. Write 1 to clear; writing 0 has no effect.
  - 0x14 CAPTURE: 32 bits, read-only.
  - 0x18 and 0x1C read 0; writes are ignored.
- **Writes.** Honour each byte strobe independently.
- **Prescaler.** `pcnt` counts down while EN=1.
  - `tick` = EN && `pcnt`==0; on `tick`, `pcnt` reloads to PRESC.
  - PRESC=0 gives a tick every cycle.
  - Writing CTRL or PRESC reloads `pcnt` to the new PRESC value.
  - When EN=0, `pcnt` holds.
- **Counter, on `tick`:**
  - COUNT!=0: COUNT decrements by 1.
  - COUNT==0: EXP sets. If AUTO=1, COUNT loads RELOAD. If AUTO=0, EN clears and COUNT stays 0.
- **Interrupt.** `irq` = EXP && IRQEN, combinational from registers. It stays high until software clears EXP.
- **Simultaneous events:**
  - A bus write to COUNT wins over a tick decrement or reload in the same cycle.
  - An EXP set event wins over a W1C clear of EXP in the same cycle; the same rule applies to CAP.
  - A CTRL write clearing EN wins over the auto-clear of EN.
- **Reset.** All registers, `pcnt`, `irq`, `iomem_ready` and `iomem_rdata` go to 0. Reset mid-transaction drops the transaction: no ready is issued.

## Timing
- **Ready latency.** `iomem_ready` rises in the cycle after `sel` is first seen high: `ready <= sel && !ready`. It is high for exactly one cycle.
- **Back-to-back transactions.** The master deasserts or changes `iomem_valid` after ready. A new transaction can start the cycle after ready; ready is therefore issued at most every other cycle.
- **Read data.** `iomem_rdata` is registered and captured in the same edge that raises ready. A read of COUNT returns its value before that edge's update. Outside ready, `iomem_rdata` = 0.
- **Write timing.** A write takes effect on the edge that raises ready. Register effects are visible on the following cycle.
- **Expiry to interrupt.** `irq` rises one cycle after the tick that finds COUNT==0.
- **Expiry period.** With AUTO=1 and PRESC=P, reload value R gives an expiry every (R+1)·(P+1) cycles.

## Configuration
- Macro: `PICOSOC_TIMER_CAPTURE_EN`.
- **Defined:**
  - `capture_in` passes through a 2-flop synchronizer, then an edge-detect flop.
  - A synchronized rising edge latches the current COUNT into CAPTURE and sets CAP.
  - Latency from the `capture_in` rise to CAP set is 3 cycles.
  - `irq` = (EXP || CAP) && IRQEN.
- **Undefined:**
  - No synchronizer or CAPTURE register is built.
  - CAPTURE and STATUS[1] read 0; `capture_in` is unused.
  - `irq` = EXP && IRQEN.

## Test plan
- **Reset values.** Assert reset for 2 cycles, then read all offsets 0x00 to 0x1C. All return 0, `irq`=0, and each ready is a one-cycle pulse the cycle after valid.
- **One-shot.** Write PRESC=0, COUNT=3, then CTRL=0x5. EXP sets 4 cycles after the CTRL write takes effect, `irq`=1, EN reads 0 and COUNT reads 0. Writing STATUS=1 drops `irq` the next cycle.
- **Auto-reload with prescaler.** Write PRESC=1, RELOAD=4, COUNT=4, then CTRL=0x7. Expiries occur exactly 10 cycles apart across 5 periods.
- **Collisions:**
  - A COUNT write of 0x20 in the same cycle as a tick: COUNT reads 0x20.
  - A STATUS=1 write in the same cycle as expiry: EXP stays 1.
  - A byte write of wstrb=4'b0010 with data 0xAB00 to RELOAD=0: RELOAD reads 0x0000AB00.
- **Address decode.** Access 0x0300_0020 and 0x0200_0000. `iomem_ready` is never asserted. The BASE_ADDR+0x1C write is ignored and reads back 0.
- **Capture (macro defined).** Run the counter from COUNT=100 with PRESC=0 and pulse `capture_in`. CAPTURE holds the COUNT value present 3 cycles after the rise, CAP=1, and `irq`=1 with IRQEN=1.
